voq_desc_queue: RTL and testbench

VOQ_DESC_QUEUE -- requirements
Module: voq_desc_queue

---
 rtl/voq_desc_queue_pkg.sv | 13 +
 rtl/voq_desc_queue_if.sv | 32 +++
 rtl/voq_desc_queue_desc_fifo.sv | 77 +++++++
 rtl/voq_desc_queue.sv | 57 +++++
 tb/tb_voq_desc_queue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/voq_desc_queue_pkg.sv
// Shared constants for the VOQ descriptor queue slice.
// Pure definitions, no logic.
// Values here set the default geometry of the queues.
package voq_desc_queue_pkg;

  // Width of a frame start-block pointer in packet memory.
  localparam int MEM_ADDR_W = 10;
  // Default descriptors held per egress queue.
  localparam int VOQ_DEPTH  = 8;
  // Default width of each per-port drop counter.
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/voq_desc_queue_if.sv
// Per-port enqueue/dequeue bundle between the switch core and the VOQ block.
// No logic; modports fix drive direction.
// Master side drives push/flush/pop_ready, slave side drives queue status.
interface voq_desc_queue_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = voq_desc_queue_pkg::MEM_ADDR_W,
  parameter int LVL_W     = 4,
  parameter int CNT_W     = voq_desc_queue_pkg::DROP_CNT_W
);

  logic [NUM_PORTS-1:0]             push_mask_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] push_ptr_i;
  logic [NUM_PORTS-1:0]             flush_i;
  logic [NUM_PORTS-1:0]             pop_ready_i;
  logic [NUM_PORTS-1:0]             pop_valid_o;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] pop_ptr_o;
  logic [NUM_PORTS-1:0][LVL_W-1:0]  level_o;
  logic [NUM_PORTS-1:0]             full_o;
  logic [NUM_PORTS-1:0]             drop_pulse_o;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  drop_cnt_o;

  modport master (
    output push_mask_i, push_ptr_i, flush_i, pop_ready_i,
    input  pop_valid_o, pop_ptr_o, level_o, full_o, drop_pulse_o, drop_cnt_o
  );

  modport slave (
    input  push_mask_i, push_ptr_i, flush_i, pop_ready_i,
    output pop_valid_o, pop_ptr_o, level_o, full_o, drop_pulse_o, drop_cnt_o
  );

endinterface

// File: rtl/voq_desc_queue_desc_fifo.sv
// Single FWFT descriptor queue with flush and saturating drop counter.
// Latency 1 from push to pop_valid; head visible while non-empty.
// A push into a full queue is dropped unless a pop fires the same cycle.
module desc_fifo
  import voq_desc_queue_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = VOQ_DEPTH,
  parameter int CNT_W  = DROP_CNT_W,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_ptr,
  input  logic              flush,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [ADDR_W-1:0] pop_ptr,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              pop_fire;
  logic              accept;
  logic              drop;

  // Handshake decode: full/empty come from level, never from index compare.
  always_comb begin
    pop_fire = pop_ready && (level != '0);
    accept   = push && ((level != LVL_W'(DEPTH)) || pop_fire);
    drop     = push && !accept;
  end

  // Queue state: indices, level and drop accounting; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx     <= '0;
      wr_idx     <= '0;
      level      <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else if (flush) begin
      rd_idx     <= '0;
      wr_idx     <= '0;
      level      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      if (accept)   wr_idx <= wr_idx + IDX_W'(1);
      if (pop_fire) rd_idx <= rd_idx + IDX_W'(1);
      if (accept && !pop_fire)      level <= level + LVL_W'(1);
      else if (!accept && pop_fire) level <= level - LVL_W'(1);
      drop_pulse <= drop;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Descriptor storage is left unreset; only indices/level define contents.
  always_ff @(posedge clk) begin
    if (accept && !flush) mem[wr_idx] <= push_ptr;
  end

  // Status outputs derived purely from registered state.
  always_comb begin
    pop_valid = (level != '0);
    full      = (level == LVL_W'(DEPTH));
    pop_ptr   = pop_valid ? mem[rd_idx] : '0;
  end

endmodule

// File: rtl/voq_desc_queue.sv
// Virtual output queues: one descriptor FIFO per egress port.
// Latency 1 push-to-valid per port; no input-to-output combinational path.
// Per-port pop_valid/pop_ready; rejected pushes drop and are counted.
module voq_desc_queue
  import voq_desc_queue_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DEPTH     = VOQ_DEPTH,
  parameter int CNT_W     = DROP_CNT_W,
  parameter int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  voq_desc_queue_if.slave    q
);

  logic [NUM_PORTS-1:0]             pop_valid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] pop_ptr;
  logic [NUM_PORTS-1:0][LVL_W-1:0]  level;
  logic [NUM_PORTS-1:0]             full;
  logic [NUM_PORTS-1:0]             drop_pulse;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  drop_cnt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    desc_fifo #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W),
      .LVL_W  (LVL_W)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (q.push_mask_i[p]),
      .push_ptr   (q.push_ptr_i[p]),
      .flush      (q.flush_i[p]),
      .pop_ready  (q.pop_ready_i[p]),
      .pop_valid  (pop_valid[p]),
      .pop_ptr    (pop_ptr[p]),
      .level      (level[p]),
      .full       (full[p]),
      .drop_pulse (drop_pulse[p]),
      .drop_cnt   (drop_cnt[p])
    );
  end

  // Gather per-port status onto the interface.
  always_comb begin
    q.pop_valid_o  = pop_valid;
    q.pop_ptr_o    = pop_ptr;
    q.level_o      = level;
    q.full_o       = full;
    q.drop_pulse_o = drop_pulse;
    q.drop_cnt_o   = drop_cnt;
  end

endmodule

// File: tb/tb_voq_desc_queue.sv
// Directed self-checking bench for voq_desc_queue (4 ports, depth 8, 2-bit drop counters).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_voq_desc_queue;

  localparam int NP = 4;
  localparam int AW = voq_desc_queue_pkg::MEM_ADDR_W;
  localparam int D  = 8;
  localparam int CW = 2;
  localparam int LW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  voq_desc_queue_if #(.NUM_PORTS(NP), .ADDR_W(AW), .LVL_W(LW), .CNT_W(CW)) q_if ();

  voq_desc_queue #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DEPTH     (D),
    .CNT_W     (CW),
    .LVL_W     (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q_if.push_mask_i = '0;
    q_if.push_ptr_i  = '0;
    q_if.flush_i     = '0;
    q_if.pop_ready_i = '0;
  endtask

  task automatic push_one(input int p, input logic [AW-1:0] ptr);
    q_if.push_mask_i[p] = 1'b1;
    q_if.push_ptr_i[p]  = ptr;
    step();
    idle();
  endtask

  task automatic pop_one(input int p);
    q_if.pop_ready_i[p] = 1'b1;
    step();
    idle();
  endtask

  initial begin
    idle();
    step();
    step();
    // Reset state
    check("rst_valid", 64'(q_if.pop_valid_o), 64'h0);
    check("rst_level", 64'(q_if.level_o), 64'h0);
    check("rst_full", 64'(q_if.full_o), 64'h0);
    check("rst_pulse", 64'(q_if.drop_pulse_o), 64'h0);
    check("rst_cnt", 64'(q_if.drop_cnt_o), 64'h0);
    check("rst_ptr", 64'(q_if.pop_ptr_o), 64'h0);
    #2 rst = 1'b0;
    step();

    // Pop request on empty queues does nothing
    q_if.pop_ready_i = '1;
    step();
    idle();
    check("empty_pop_level", 64'(q_if.level_o), 64'h0);

    // Single push to port 0, latency 1
    push_one(0, AW'('h12));
    check("p0_valid_mask", 64'(q_if.pop_valid_o), 64'h1);
    check("p0_ptr", 64'(q_if.pop_ptr_o[0]), 64'h12);
    check("p0_level", 64'(q_if.level_o[0]), 64'd1);
    check("p1_level_idle", 64'(q_if.level_o[1]), 64'd0);
    pop_one(0);
    check("p0_empty_after_pop", 64'(q_if.pop_valid_o[0]), 64'h0);

    // Nine pushes to port 1: eight accepted, one dropped
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      q_if.push_mask_i[1] = 1'b1;
      q_if.push_ptr_i[1]  = AW'('h20 + i);
      step();
      if (q_if.drop_pulse_o[1]) pulses++;
    end
    idle();
    step();
    if (q_if.drop_pulse_o[1]) pulses++;
    check("p1_full", 64'(q_if.full_o[1]), 64'h1);
    check("p1_level8", 64'(q_if.level_o[1]), 64'd8);
    check("p1_pulses", 64'(pulses), 64'd1);
    check("p1_cnt", 64'(q_if.drop_cnt_o[1]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("p1_order", 64'(q_if.pop_ptr_o[1]), 64'('h20 + i));
      pop_one(1);
    end
    check("p1_drained", 64'(q_if.pop_valid_o[1]), 64'h0);

    // Port 2 full, push with simultaneous pop
    for (int i = 0; i < 8; i++) push_one(2, AW'('h40 + i));
    check("p2_full", 64'(q_if.full_o[2]), 64'h1);
    q_if.push_mask_i[2] = 1'b1;
    q_if.push_ptr_i[2]  = AW'('h3F);
    q_if.pop_ready_i[2] = 1'b1;
    step();
    idle();
    check("p2_no_pulse", 64'(q_if.drop_pulse_o[2]), 64'h0);
    check("p2_level_kept", 64'(q_if.level_o[2]), 64'd8);
    check("p2_cnt", 64'(q_if.drop_cnt_o[2]), 64'd0);
    for (int i = 1; i < 8; i++) begin
      check("p2_order", 64'(q_if.pop_ptr_o[2]), 64'('h40 + i));
      pop_one(2);
    end
    check("p2_wrap_ptr", 64'(q_if.pop_ptr_o[2]), 64'h3F);
    pop_one(2);
    check("p2_drained", 64'(q_if.level_o[2]), 64'd0);

    // Broadcast push to all ports
    q_if.push_mask_i = 4'b1111;
    q_if.push_ptr_i[0] = AW'('h101);
    q_if.push_ptr_i[1] = AW'('h202);
    q_if.push_ptr_i[2] = AW'('h303);
    q_if.push_ptr_i[3] = AW'('h3A4);
    step();
    idle();
    check("bc_valid", 64'(q_if.pop_valid_o), 64'hF);
    check("bc_ptr0", 64'(q_if.pop_ptr_o[0]), 64'h101);
    check("bc_ptr1", 64'(q_if.pop_ptr_o[1]), 64'h202);
    check("bc_ptr2", 64'(q_if.pop_ptr_o[2]), 64'h303);
    check("bc_ptr3", 64'(q_if.pop_ptr_o[3]), 64'h3A4);
    for (int p = 0; p < NP; p++) check("bc_level", 64'(q_if.level_o[p]), 64'd1);
    q_if.pop_ready_i = '1;
    step();
    idle();
    check("bc_drained", 64'(q_if.level_o), 64'h0);

    // Flush port 3 with simultaneous push; port 0 push alongside is unaffected
    for (int i = 0; i < 5; i++) push_one(3, AW'('h70 + i));
    check("p3_level5", 64'(q_if.level_o[3]), 64'd5);
    q_if.flush_i[3]     = 1'b1;
    q_if.push_mask_i    = 4'b1001;
    q_if.push_ptr_i[3]  = AW'('h7F);
    q_if.push_ptr_i[0]  = AW'('h55);
    step();
    idle();
    check("p3_flush_level", 64'(q_if.level_o[3]), 64'd0);
    check("p3_flush_valid", 64'(q_if.pop_valid_o[3]), 64'h0);
    check("p3_flush_cnt", 64'(q_if.drop_cnt_o[3]), 64'd0);
    check("p3_flush_pulse", 64'(q_if.drop_pulse_o[3]), 64'h0);
    check("p0_indep_ptr", 64'(q_if.pop_ptr_o[0]), 64'h55);
    pop_one(0);
    push_one(3, AW'('h66));
    check("p3_after_flush", 64'(q_if.pop_ptr_o[3]), 64'h66);
    pop_one(3);

    // Five drops on port 0 saturate the 2-bit counter at 3
    for (int i = 0; i < 8; i++) push_one(0, AW'('h60 + i));
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      q_if.push_mask_i[0] = 1'b1;
      q_if.push_ptr_i[0]  = AW'('h1E0 + i);
      step();
      if (q_if.drop_pulse_o[0]) pulses++;
    end
    idle();
    step();
    if (q_if.drop_pulse_o[0]) pulses++;
    check("p0_sat_cnt", 64'(q_if.drop_cnt_o[0]), 64'd3);
    check("p0_sat_pulses", 64'(pulses), 64'd5);
    check("p0_head_kept", 64'(q_if.pop_ptr_o[0]), 64'h60);
    check("p0_level_kept", 64'(q_if.level_o[0]), 64'd8);

    // Asynchronous reset mid-operation clears everything at once
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(q_if.pop_valid_o), 64'h0);
    check("arst_level", 64'(q_if.level_o), 64'h0);
    check("arst_cnt", 64'(q_if.drop_cnt_o), 64'h0);
    check("arst_ptr", 64'(q_if.pop_ptr_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    push_one(0, AW'('h2AA));
    check("post_rst_ptr", 64'(q_if.pop_ptr_o[0]), 64'h2AA);
    check("post_rst_level", 64'(q_if.level_o[0]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
